// File: rtl/imm_extend_stage_pkg.sv
// Shared definitions for the immediate-extend stage: the imm_src encoding
// and the width of an instruction word with its 7-bit opcode removed.
package imm_extend_stage_pkg;

  localparam int INSTR_W = 25;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_RSVD  = 3'b111
  } imm_src_e;

endpackage

// File: rtl/imm_extend_stage_decode.sv
// Combinational immediate decoder: builds the extended immediate for one
// opcode-stripped instruction and flags the reserved format code.
module imm_decode
  import imm_extend_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [INSTR_W+6:7]    instr_i,
  input  logic [2:0]            imm_src_i,
  output logic [DATA_WIDTH-1:0] imm_o,
  output logic                  err_o
);

  logic       sgn;
  logic [5:0] shamt;

  assign sgn = instr_i[31];
  // RV64 shift amounts use one extra bit of the instruction.
  assign shamt = {(DATA_WIDTH == 64) ? instr_i[25] : 1'b0, instr_i[24:20]};

  always_comb begin
    imm_o = '0;
    err_o = 1'b0;
    case (imm_src_e'(imm_src_i))
      IMM_I:     imm_o = {{(DATA_WIDTH-12){sgn}}, instr_i[31:20]};
      IMM_S:     imm_o = {{(DATA_WIDTH-12){sgn}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:     imm_o = {{(DATA_WIDTH-13){sgn}}, instr_i[31], instr_i[7],
                          instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_J:     imm_o = {{(DATA_WIDTH-21){sgn}}, instr_i[31], instr_i[19:12],
                          instr_i[20], instr_i[30:21], 1'b0};
      IMM_U:     imm_o = {{(DATA_WIDTH-32){sgn}}, instr_i[31:12], 12'b0};
      IMM_SHAMT: imm_o = {{(DATA_WIDTH-6){1'b0}}, shamt};
      IMM_ZIMM:  imm_o = {{(DATA_WIDTH-5){1'b0}}, instr_i[19:15]};
      default:   err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Immediate-extend pipeline stage: decodes at the input, then buffers results
// in an output register plus a skid register so in_ready can be registered.
module imm_extend_stage
  import imm_extend_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:7]           instr,
  input  logic [2:0]            imm_src,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] imm_ext,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  src_err
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] imm;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  err;
  } entry_t;

  entry_t new_ent;
  entry_t out_q, out_d, skid_q, skid_d;
  logic   out_vld_q, out_vld_d;
  logic   skid_vld_q, skid_vld_d;
  logic   in_rdy_q, in_rdy_d;
  logic   accept;

  imm_decode #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .instr_i   (instr),
    .imm_src_i (imm_src),
    .imm_o     (new_ent.imm),
    .err_o     (new_ent.err)
  );
  assign new_ent.tag = in_tag;

  assign accept = in_valid && in_rdy_q && !flush;

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || out_ready) begin
      // Output slot frees up: the older skid entry always goes first.
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_d     = new_ent;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = new_ent;
      skid_vld_d = 1'b1;
    end
    in_rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b1;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= in_rdy_d;
    end
  end

  assign in_ready  = in_rdy_q;
  assign out_valid = out_vld_q;
  assign imm_ext   = out_q.imm;
  assign out_tag   = out_q.tag;
  assign src_err   = out_q.err;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage: 32- and 64-bit instances share inputs.
module tb_imm_extend_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [24:0] instr;
  logic [2:0]  imm_src;
  logic [4:0]  in_tag;

  logic        rdy32, vld32, err32, rdy64, vld64, err64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0]  tag32, tag64;

  int cmp_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  imm_extend_stage #(.DATA_WIDTH(32), .TAG_WIDTH(5)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(vld32),
    .out_ready(out_ready), .imm_ext(imm32), .out_tag(tag32), .src_err(err32)
  );

  imm_extend_stage #(.DATA_WIDTH(64), .TAG_WIDTH(5)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(vld64),
    .out_ready(out_ready), .imm_ext(imm64), .out_tag(tag64), .src_err(err64)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer an I-type whose immediate equals the tag, so data and tag both track order.
  task automatic offer_tag(input logic [4:0] t);
    logic [31:0] w;
    w        = {7'd0, t, 20'd0};
    instr    = w[31:7];
    imm_src  = 3'b000;
    in_tag   = t;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; imm_src = '0; in_tag = '0;
    step(); step();
    rst = 1'b0;
    cmp_cnt++;
    if ({vld32, rdy32, imm32, tag32, err32} !== {1'b0, 1'b1, 32'd0, 5'd0, 1'b0}) begin
      fail_cnt++;
      $display("FAIL reset32: vld=%b rdy=%b imm=%h tag=%h err=%b exp 0 1 0 0 0", vld32, rdy32, imm32, tag32, err32);
    end
    cmp_cnt++;
    if ({vld64, rdy64, imm64, tag64, err64} !== {1'b0, 1'b1, 64'd0, 5'd0, 1'b0}) begin
      fail_cnt++;
      $display("FAIL reset64: vld=%b rdy=%b imm=%h tag=%h err=%b exp 0 1 0 0 0", vld64, rdy64, imm64, tag64, err64);
    end
  endtask

  task automatic test_decode();
    logic [31:0] vw  [9] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h0010006F,
                             32'h800000B7, 32'h800000B7, 32'h83F00013, 32'h800F8073,
                             32'h00500093};
    logic [2:0]  vs  [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd5, 3'd6, 3'd0};
    logic [31:0] e32 [9] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800,
                             32'h80000000, 32'h0, 32'h1F, 32'h1F, 32'h5};
    logic [63:0] e64 [9] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                             64'h800, 64'hFFFFFFFF80000000, 64'h0, 64'h3F, 64'h1F, 64'h5};
    logic        ee  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] w;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      w        = vw[i];
      instr    = w[31:7];
      imm_src  = vs[i];
      in_tag   = 5'(i + 1);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      cmp_cnt++;
      if ({vld32, imm32, tag32, err32} !== {1'b1, e32[i], 5'(i + 1), ee[i]}) begin
        fail_cnt++;
        $display("FAIL decode32[%0d]: vld=%b imm=%h tag=%h err=%b exp 1 %h %h %b",
                 i, vld32, imm32, tag32, err32, e32[i], 5'(i + 1), ee[i]);
      end
      cmp_cnt++;
      if ({vld64, imm64, tag64, err64} !== {1'b1, e64[i], 5'(i + 1), ee[i]}) begin
        fail_cnt++;
        $display("FAIL decode64[%0d]: vld=%b imm=%h tag=%h err=%b exp 1 %h %h %b",
                 i, vld64, imm64, tag64, err64, e64[i], 5'(i + 1), ee[i]);
      end
      step();
      cmp_cnt++;
      if (vld32 !== 1'b0) begin
        fail_cnt++;
        $display("FAIL decode_drain[%0d]: vld=%b exp 0", i, vld32);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] exp_tag [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
    logic       exp_rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b0;
    offer_tag(5'd1); step();
    cmp_cnt++;
    if ({vld32, tag32, rdy32} !== {1'b1, 5'd1, 1'b1}) begin
      fail_cnt++;
      $display("FAIL bp_first: vld=%b tag=%h rdy=%b exp 1 01 1", vld32, tag32, rdy32);
    end
    offer_tag(5'd2); step();
    cmp_cnt++;
    if ({vld32, tag32, imm32, rdy32} !== {1'b1, 5'd1, 32'd1, 1'b0}) begin
      fail_cnt++;
      $display("FAIL bp_full: vld=%b tag=%h imm=%h rdy=%b exp 1 01 1 0", vld32, tag32, imm32, rdy32);
    end
    offer_tag(5'd3); step();
    cmp_cnt++;
    if ({vld32, tag32, imm32, err32, rdy32} !== {1'b1, 5'd1, 32'd1, 1'b0, 1'b0}) begin
      fail_cnt++;
      $display("FAIL bp_stable: vld=%b tag=%h imm=%h err=%b rdy=%b exp 1 01 1 0 0",
               vld32, tag32, imm32, err32, rdy32);
    end
    // Release: tag 3 stays offered; it was refused while full and must be accepted once.
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      if (i == 3) offer_tag(5'd4);
      step();
      cmp_cnt++;
      if ({vld32, tag32, imm32, rdy32} !== {1'b1, exp_tag[i], 32'(exp_tag[i]), exp_rdy[i]}) begin
        fail_cnt++;
        $display("FAIL bp_order[%0d]: vld=%b tag=%h imm=%h rdy=%b exp 1 %h %h %b",
                 i, vld32, tag32, imm32, rdy32, exp_tag[i], 32'(exp_tag[i]), exp_rdy[i]);
      end
    end
    in_valid = 1'b0;
    step();
    cmp_cnt++;
    if (vld32 !== 1'b0) begin
      fail_cnt++;
      $display("FAIL bp_empty: vld=%b exp 0", vld32);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer_tag(5'd5); step();
    offer_tag(5'd6); step();
    offer_tag(5'd7); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    cmp_cnt++;
    if ({vld32, rdy32} !== {1'b0, 1'b1}) begin
      fail_cnt++;
      $display("FAIL flush: vld=%b rdy=%b exp 0 1", vld32, rdy32);
    end
    out_ready = 1'b1;
    step();
    cmp_cnt++;
    if (vld32 !== 1'b0) begin
      fail_cnt++;
      $display("FAIL flush_drop: vld=%b tag=%h exp vld 0", vld32, tag32);
    end
  endtask

  task automatic test_rst_midstall();
    out_ready = 1'b0;
    offer_tag(5'd9); step();
    offer_tag(5'd10); step();
    offer_tag(5'd11); flush = 1'b1; rst = 1'b1; step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    cmp_cnt++;
    if ({vld32, rdy32, imm32, tag32, err32} !== {1'b0, 1'b1, 32'd0, 5'd0, 1'b0}) begin
      fail_cnt++;
      $display("FAIL rst_stall32: vld=%b rdy=%b imm=%h tag=%h err=%b exp 0 1 0 0 0", vld32, rdy32, imm32, tag32, err32);
    end
    cmp_cnt++;
    if ({vld64, imm64, tag64, err64} !== {1'b0, 64'd0, 5'd0, 1'b0}) begin
      fail_cnt++;
      $display("FAIL rst_stall64: vld=%b imm=%h tag=%h err=%b exp 0 0 0 0", vld64, imm64, tag64, err64);
    end
    out_ready = 1'b1;
    step();
    cmp_cnt++;
    if (vld32 !== 1'b0) begin
      fail_cnt++;
      $display("FAIL rst_drop: vld=%b exp 0", vld32);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer_tag(5'(12 + i));
      step();
      cmp_cnt++;
      if ({vld32, tag32, imm32, rdy32} !== {1'b1, 5'(12 + i), 32'(12 + i), 1'b1}) begin
        fail_cnt++;
        $display("FAIL b2b[%0d]: vld=%b tag=%h imm=%h rdy=%b exp 1 %h %h 1",
                 i, vld32, tag32, imm32, rdy32, 5'(12 + i), 32'(12 + i));
      end
    end
    in_valid = 1'b0;
    step();
    cmp_cnt++;
    if (vld32 !== 1'b0) begin
      fail_cnt++;
      $display("FAIL b2b_end: vld=%b exp 0", vld32);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_rst_midstall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/imm_extend_stage.md
IMM_EXTEND_STAGE -- requirements
Module: imm_extend_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, immediate output width; legal values are 32 and 64.
REQ-002 SHALL have parameter TAG_WIDTH, default 5, width of the sideband tag carried with each instruction (e.g. rd index).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port flush, input, 1, discard all buffered entries.
REQ-006 SHALL have port in_valid, input, 1, an upstream instruction is offered.
REQ-007 SHALL have port in_ready, output, 1, the block can accept this cycle.
REQ-008 SHALL have port instr, input, 25 ([31:7]), the instruction without the opcode.
REQ-009 SHALL have port imm_src, input, 3, immediate format select.
REQ-010 SHALL have port in_tag, input, TAG_WIDTH, sideband carried unchanged.
REQ-011 SHALL have port out_valid, output, 1, imm_ext/out_tag/src_err are valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts this cycle.
REQ-013 SHALL have port imm_ext, output, DATA_WIDTH, the extended immediate.
REQ-014 SHALL have port out_tag, output, TAG_WIDTH, tag of the presented entry.
REQ-015 SHALL have port src_err, output, 1, the presented entry used the reserved imm_src.

Function
REQ-016 SHALL decode imm_src: 000 I {instr[31:20]}; 001 S {instr[31:25],instr[11:7]}; 010 B {instr[31],instr[7],instr[30:25],instr[11:8],0}; 011 J {instr[31],instr[19:12],instr[20],instr[30:21],0}; 100 U {instr[31:12],12'b0}; all of these sign-extended from instr[31] to DATA_WIDTH.
REQ-017 SHALL decode 101 as shift amount, zero-extended: instr[24:20] when DATA_WIDTH=32, instr[25:20] when DATA_WIDTH=64.
REQ-018 SHALL decode 110 as CSR zimm, instr[19:15] zero-extended.
REQ-019 SHALL decode 111 as imm_ext zero with src_err=1; src_err is 0 for every other code.
REQ-020 SHALL accept an entry when in_valid && in_ready, and transfer an entry out when out_valid && out_ready.
REQ-021 SHALL register the decoded result, giving a latency of exactly 1 cycle from acceptance to out_valid when the output is empty.
REQ-022 SHALL hold a 2-entry buffer (output register plus skid register); in_ready SHALL be a registered signal equal to "skid entry empty".
REQ-023 SHALL keep imm_ext, out_tag and src_err stable while out_valid && !out_ready.
REQ-024 SHALL, when the output is stalled and an entry is accepted, place it in the skid entry; on the next output transfer the skid entry moves to the output and in_ready rises in the following cycle.
REQ-025 SHALL, on simultaneous accept and output transfer with the skid entry empty, load the new entry straight into the output register with no bubble (throughput 1 per cycle).
REQ-026 SHALL preserve strict FIFO order; entries are never dropped or duplicated except by flush/rst.
REQ-027 SHALL, on flush, clear both entries at the next edge (out_valid=0, in_ready=1); an entry offered in the flush cycle is not accepted.
REQ-028 SHALL let rst take priority over flush and over any handshake.

Reset
REQ-029 SHALL, on rst, set out_valid=0, in_ready=1, imm_ext=0, out_tag=0, src_err=0, and empty the skid entry, including when rst arrives mid-stall.
REQ-030 SHALL present the reset values on the first cycle after rst deasserts, and accept input on that cycle.

Structure
REQ-031 SHALL place the imm_src encoding (enum of the 8 codes) and the opcode-stripped instruction width constant (25) in a shared package used by the decoder and control unit.
REQ-032 SHALL implement decoding (REQ-016..019) in a combinational sub-module imm_decode, instantiated once at the block input; buffering stays in imm_extend_stage.

Verification
REQ-033 SHALL check I-type: instr=0xFFF00093>>7, imm_src=000 -> imm_ext=0xFFFFFFFF one cycle later (0xFFFFFFFFFFFFFFFF at DATA_WIDTH=64).
REQ-034 SHALL check S/B/J: 0xFE112E23 S -> 0xFFFFFFFC; 0xFE000CE3 B -> 0xFFFFFFF8; 0x0010006F J -> 0x00000800.
REQ-035 SHALL check U at DATA_WIDTH=64: 0x800000B7, imm_src=100 -> 0xFFFFFFFF80000000; imm_src=111 -> imm_ext 0, src_err 1.
REQ-036 SHALL check backpressure: stream tags 1..4 back-to-back with out_ready held 0 for 3 cycles -> in_ready falls after 2 accepts, tags emerge 1,2,3,4 unchanged, outputs stable while stalled.
REQ-037 SHALL check flush and reset: 2 buffered entries, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered entry not seen; repeat with rst -> all outputs zero.
REQ-038 SHALL check full throughput: in_valid and out_ready held 1 for 8 cycles -> 8 results on consecutive cycles, in_ready never falls.
